// File: rtl/timer_sched_pkg.sv
// State encoding and timer register map shared by the interval scheduler.
package timer_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        EN,
        RD,
        WAIT,
        CMP,
        DIS
    } sched_state_t;

    localparam logic        CTRL_ADDR    = 1'b0;
    localparam logic        COUNT_ADDR   = 1'b1;
    localparam logic [31:0] CTRL_ENABLE  = 32'd1;
    localparam logic [31:0] CTRL_DISABLE = 32'd0;

endpackage

// File: rtl/timer_interval_scheduler.sv
// Avalon-MM master that arms the custom timer, polls its counter and emits
// periodic or one-shot interval ticks.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | writing CTRL=0 (clear and disable timer)
// EN    | writing CTRL=1 (enable timer)
// RD    | issuing COUNTER read
// WAIT  | waiting READ_LATENCY cycles, capturing readdata on the last one
// CMP   | comparing captured count against period
// DIS   | writing CTRL=0 before returning to IDLE
module timer_interval_scheduler
    import timer_sched_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int TICK_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  oneshot,
    input  logic [31:0]           period,
    output logic                  busy,
    output logic                  tick,
    output logic                  err,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [31:0]           last_count,
    output logic                  tmr_address,
    output logic                  tmr_read,
    output logic                  tmr_write,
    output logic [31:0]           tmr_writedata,
    input  logic [31:0]           tmr_readdata
);

    localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

    sched_state_t          r_state;
    sched_state_t          w_next;
    logic [31:0]           r_period;
    logic                  r_oneshot;
    logic                  r_stop_pend;
    logic [1:0]            r_wait_cnt;
    logic [31:0]           r_captured;
    logic [TICK_CNT_W-1:0] r_tick_count;
    logic [31:0]           r_last_count;
    logic                  r_tick;
    logic                  r_err;
    logic                  r_rd;
    logic                  r_wr;
    logic                  r_addr;
    logic [31:0]           r_wdata;

    logic                  w_accept;
    logic                  w_reject;
    logic                  w_stop_now;
    logic                  w_expired;
    logic                  w_tick;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_addr;
    logic [31:0]           w_wdata;

    // stop in the same IDLE cycle as start drops the start
    assign w_accept   = start && !stop && (period != 32'd0);
    assign w_reject   = start && !stop && (period == 32'd0);
    assign w_stop_now = r_stop_pend || stop;
    assign w_expired  = (r_captured >= r_period);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = CLR;
            // a pending stop replaces the CTRL=1 write with the disable write
            CLR:  w_next = w_stop_now ? DIS : EN;
            EN:   w_next = RD;
            RD:   w_next = WAIT;
            WAIT: if (r_wait_cnt == 2'd0) w_next = CMP;
            CMP: begin
                if (w_stop_now)     w_next = DIS;
                else if (w_expired) w_next = r_oneshot ? DIS : CLR;
                else                w_next = RD;
            end
            DIS:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // strobes are decoded from the next state so they are registered and
    // coincide with the state that owns the bus cycle
    always_comb begin
        w_wr    = (w_next == CLR) || (w_next == EN) || (w_next == DIS);
        w_rd    = (w_next == RD);
        w_addr  = w_rd ? COUNT_ADDR : CTRL_ADDR;
        w_wdata = (w_next == EN) ? CTRL_ENABLE : CTRL_DISABLE;
        w_tick  = (r_state == CMP) && !w_stop_now && w_expired;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period     <= '0;
            r_oneshot    <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_wait_cnt   <= '0;
            r_captured   <= '0;
            r_tick_count <= '0;
            r_last_count <= '0;
            r_tick       <= 1'b0;
            r_err        <= 1'b0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_tick <= w_tick;
            r_err  <= (r_state == IDLE) && w_reject;
            r_rd   <= w_rd;
            r_wr   <= w_wr;
            r_addr <= w_addr;
            r_wdata <= w_wdata;

            if ((r_state == IDLE) && w_accept) begin
                r_period     <= period;
                r_oneshot    <= oneshot;
                r_tick_count <= '0;
            end

            if ((r_state == IDLE) || (r_state == DIS)) begin
                r_stop_pend <= 1'b0;
            end else if (stop) begin
                r_stop_pend <= 1'b1;
            end

            if (r_state == RD) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if ((r_state == WAIT) && (r_wait_cnt != 2'd0)) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end

            if ((r_state == WAIT) && (r_wait_cnt == 2'd0)) begin
                r_captured <= tmr_readdata;
            end

            if (w_tick) begin
                r_tick_count <= r_tick_count + 1'b1;
                r_last_count <= r_captured;
            end
        end
    end

    assign busy          = (r_state != IDLE);
    assign tick          = r_tick;
    assign err           = r_err;
    assign tick_count    = r_tick_count;
    assign last_count    = r_last_count;
    assign tmr_address   = r_addr;
    assign tmr_read      = r_rd;
    assign tmr_write     = r_wr;
    assign tmr_writedata = r_wdata;

endmodule

// File: tb/tb_timer_interval_scheduler.sv
// Scoreboard bench for timer_interval_scheduler with a behavioural timer slave.
module tb_timer_interval_scheduler;

    localparam int RL   = 1;
    localparam int TW   = 16;
    localparam int LOOP = 2 + RL;

    // event codes: {kind, address, data}; kind 0 = write, 1 = read, 2 = tick
    localparam logic [34:0] EV_W0 = {2'd0, 1'b0, 32'd0};
    localparam logic [34:0] EV_W1 = {2'd0, 1'b0, 32'd1};
    localparam logic [34:0] EV_RD = {2'd1, 1'b1, 32'd0};
    localparam logic [34:0] EV_T  = {2'd2, 1'b0, 32'd0};

    typedef struct packed {
        logic [31:0]   last;
        logic [TW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          oneshot = 1'b0;
    logic [31:0]   period = '0;
    logic          busy, tick, err;
    logic [TW-1:0] tick_count;
    logic [31:0]   last_count;
    logic          tmr_address, tmr_read, tmr_write;
    logic [31:0]   tmr_writedata, tmr_readdata;

    int          checks = 0;
    int          errors = 0;
    int          bus_cnt = 0;
    logic [34:0] evq[$];
    exp_t        expq[$];
    exp_t        mon_e;

    timer_interval_scheduler #(.READ_LATENCY(RL), .TICK_CNT_W(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .oneshot(oneshot),
        .period(period), .busy(busy), .tick(tick), .err(err),
        .tick_count(tick_count), .last_count(last_count),
        .tmr_address(tmr_address), .tmr_read(tmr_read), .tmr_write(tmr_write),
        .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata)
    );

    always #5 clk = ~clk;

    // timer slave: CTRL bit0 enables counting, writing 0 also clears the counter
    logic [31:0] tm_count;
    logic        tm_en;
    logic [31:0] tm_pipe [RL];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tm_count <= '0;
            tm_en    <= 1'b0;
            for (int i = 0; i < RL; i++) tm_pipe[i] <= '0;
        end else begin
            if (tmr_write && (tmr_address == 1'b0)) begin
                tm_en <= tmr_writedata[0];
                if (!tmr_writedata[0]) tm_count <= '0;
            end else if (tm_en) begin
                tm_count <= tm_count + 32'd1;
            end
            tm_pipe[0] <= (tmr_read && tmr_address) ? tm_count : 32'hFFFF_FFFF;
            for (int i = 1; i < RL; i++) tm_pipe[i] <= tm_pipe[i-1];
        end
    end
    assign tmr_readdata = tm_pipe[RL-1];

    always @(negedge clk) begin
        if (reset) begin
            if (tick) begin
                evq.push_back(EV_T);
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick: tick_count=%0d last_count=%0d, required no tick",
                             tick_count, last_count);
                end else begin
                    mon_e = expq.pop_front();
                    if (last_count !== mon_e.last || tick_count !== mon_e.cnt) begin
                        errors++;
                        $display("FAIL tick_values: last_count=%0d tick_count=%0d, required %0d/%0d",
                                 last_count, tick_count, mon_e.last, mon_e.cnt);
                    end
                end
            end
            if (tmr_write) evq.push_back({2'd0, tmr_address, tmr_writedata});
            if (tmr_read)  evq.push_back({2'd1, tmr_address, 32'd0});
            if (tmr_read || tmr_write) begin
                bus_cnt++;
                checks++;
                if (tmr_read && tmr_write) begin
                    errors++;
                    $display("FAIL rd_wr_overlap: read=%0b write=%0b, required not both", tmr_read, tmr_write);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // poll samples land on multiples of the loop length, starting at 0
    function automatic logic [31:0] ref_last(input logic [31:0] p);
        return ((p + LOOP - 1) / LOOP) * LOOP;
    endfunction

    task automatic push_exp(input logic [31:0] p, input int n);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            e.last = ref_last(p);
            e.cnt  = TW'(k);
            expq.push_back(e);
        end
    endtask

    task automatic do_start(input logic [31:0] p, input logic os, input logic st);
        @(posedge clk); #1;
        start = 1'b1; period = p; oneshot = os; stop = st;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic stop_pulse();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (expq.size() != 0 && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d ticks outstanding, required 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, busy, 0);
    endtask

    task automatic check_trace(input int base, input logic os, input int n, input string name);
        int nt = 0;
        chk({name, "_trace_len"}, evq.size() >= base + 3, 1);
        if (evq.size() >= base + 3) begin
            chk({name, "_first_clr"}, evq[base], EV_W0);
            chk({name, "_first_en"}, evq[base+1], EV_W1);
            chk({name, "_first_rd"}, evq[base+2], EV_RD);
        end
        for (int i = base; i < evq.size(); i++) begin
            if (evq[i] == EV_T) begin
                nt++;
                chk({name, "_post_tick_w0"}, (i + 1 < evq.size()) ? evq[i+1] : '1, EV_W0);
                if (!os) chk({name, "_post_tick_w1"}, (i + 2 < evq.size()) ? evq[i+2] : '1, EV_W1);
            end
        end
        chk({name, "_tick_total"}, nt, n);
        chk({name, "_last_dis"}, evq[evq.size()-1], EV_W0);
    endtask

    task automatic run_case(input logic [31:0] p, input logic os, input int n, input string name);
        int base = evq.size();
        push_exp(p, n);
        do_start(p, os, 1'b0);
        wait_drain(name);
        if (!os) stop_pulse();
        wait_idle(name);
        chk({name, "_tick_count"}, tick_count, n);
        check_trace(base, os, n, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          b;
        int          base;
        logic [31:0] p;
        logic        os;

        #100;
        chk("rst_ctrl", {busy, tick, err, tmr_read, tmr_write, tmr_address}, 0);
        chk("rst_counts", {tick_count, last_count}, 0);
        chk("rst_wdata", tmr_writedata, 0);
        #100 reset = 1'b1;
        b = bus_cnt;
        repeat (10) @(negedge clk);
        chk("post_reset_bus", bus_cnt - b, 0);
        chk("post_reset_busy", busy, 0);

        run_case(32'd10, 1'b1, 1, "oneshot10");
        run_case(32'd20, 1'b0, 19, "periodic20");

        for (int r = 0; r < 6; r++) begin
            p  = $urandom_range(1, 50);
            os = 1'($urandom_range(0, 1));
            n  = os ? 1 : $urandom_range(1, 4);
            run_case(p, os, n, "rand");
        end

        // second start while busy must not change period or mode
        base = evq.size();
        push_exp(32'd10, 1);
        do_start(32'd10, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        do_start(32'd40, 1'b0, 1'b0);
        wait_drain("busy_start");
        wait_idle("busy_start");
        chk("busy_start_tick_count", tick_count, 1);
        check_trace(base, 1'b1, 1, "busy_start");

        b = bus_cnt;
        do_start(32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("zero_err_pulse", err, 1);
        chk("zero_busy", busy, 0);
        @(negedge clk);
        chk("zero_err_clear", err, 0);
        repeat (5) @(negedge clk);
        chk("zero_no_bus", bus_cnt - b, 0);

        b = bus_cnt;
        do_start(32'd10, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        chk("start_stop_busy", busy, 0);
        chk("start_stop_no_bus", bus_cnt - b, 0);

        // stop coinciding with the expiring compare
        do_start(32'd20, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tmr_read && tm_count >= 32'd20) && n < 1000);
        chk("cmp_stop_found_read", n < 1000, 1);
        repeat (RL + 1) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tmr_write && n < 20);
        chk("cmp_stop_dis_seen", tmr_write, 1);
        chk("cmp_stop_dis_data", {tmr_address, tmr_writedata}, 0);
        @(negedge clk);
        chk("cmp_stop_busy", busy, 0);
        chk("cmp_stop_tick_count", tick_count, 0);

        // asynchronous reset in the middle of a read wait
        do_start(32'd30, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tmr_read && n < 100);
        chk("wait_rst_found_read", tmr_read, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("wait_rst_ctrl", {busy, tick, err, tmr_read, tmr_write, tmr_address}, 0);
        chk("wait_rst_counts", {tick_count, last_count}, 0);
        chk("wait_rst_wdata", tmr_writedata, 0);
        #100;
        @(negedge clk) reset = 1'b1;
        b = bus_cnt;
        repeat (10) @(negedge clk);
        chk("wait_rst_no_bus", bus_cnt - b, 0);
        chk("wait_rst_busy", busy, 0);

        chk("leftover_expected", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
